// File: rtl/uio_link_pkg.sv
// uio_link_pkg
// Shared constants and types for the bottom-edge UIO link endpoint.
// The bit indices are the same on UIO_BOT_FIN and UIO_BOT_FOUT. On FIN,
// bits 16 and 17 are the rx request toggle and the tx acknowledge toggle.
// On FOUT, the same positions carry the rx acknowledge toggle and the tx
// request toggle.
package uio_link_pkg;

  localparam int FIN_W       = 20;
  localparam int RX_DATA_LSB = 0;
  localparam int DATA_W      = 16;
  localparam int RX_REQ_BIT  = 16;
  localparam int TX_ACK_BIT  = 17;
  localparam int RSVD_BIT    = 18;
  localparam int LINK_EN_BIT = 19;

  // Link bring-up state. SYNC is a single cycle that aligns the local
  // toggles with whatever the fabric is currently presenting.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    UP   = 2'd2
  } link_state_e;

endpackage

// File: rtl/uio_link_fifo.sv
// uio_link_fifo
// Small synchronous FIFO with a flush input. The head word is read straight
// out of the storage array, so a word is visible on data_o in the cycle
// after it is pushed. The empty and full flags are registered.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   flush_i       discard all contents; takes priority over push and pop
//   push_i/data_i write data_i when the FIFO is not full
//   pop_i         drop the head word when the FIFO is not empty
//   data_o        head word (meaningful only while !empty_o)
//   empty_o       FIFO holds no words
//   full_o        FIFO holds DEPTH words
module uio_link_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is refused even when a pop happens in the
  // same cycle; the freed slot only becomes usable on the next edge.
  assign do_push = push_i & ~full_q & ~flush_i;
  assign do_pop  = pop_i & ~empty_q & ~flush_i;

  // Pointer and occupancy update. Power-of-two depth lets the pointers
  // wrap naturally, while the separate count distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are computed from the next occupancy so that they are plain
  // flops at the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == FULL_CNT);
    end
  end

  // The storage array is not reset; its contents only matter while the
  // occupancy says a slot is live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/uio_bot_link_endpoint.sv
// uio_bot_link_endpoint
// Off-fabric endpoint for the 20-wire UIO_BOT bundle. It converts the
// toggle-handshaked 16-bit duplex fabric link into host valid/ready streams.
// Each direction is buffered in a FIFO. The fabric enable line brings the
// link up and down.
// Ports:
//   UserCLK, RST    clock and synchronous active-high reset
//   UIO_BOT_FIN     [15:0] rx data, [16] rx req, [17] tx ack, [18] unused,
//                   [19] link enable
//   UIO_BOT_FOUT    [15:0] tx data, [16] rx ack, [17] tx req, [18] rx full,
//                   [19] link up
//   rx_data/rx_valid/rx_ready  host receive stream (fabric -> host)
//   tx_data/tx_valid/tx_ready  host transmit stream (host -> fabric)
//   link_up         link is in the UP state
module uio_bot_link_endpoint
  import uio_link_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic              UserCLK,
  input  logic              RST,
  input  logic [FIN_W-1:0]  UIO_BOT_FIN,
  output logic [FIN_W-1:0]  UIO_BOT_FOUT,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              link_up
);

  logic [FIN_W-1:0]  fin_q;
  link_state_e       state_q, state_d;
  logic              rx_ack_q, rx_ack_d;
  logic              tx_req_q, tx_req_d;
  logic              tx_busy_q, tx_busy_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              link_up_q;

  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              active, flush;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic              tx_ack_seen, tx_free;
  logic              rsvd_unused;

  assign rsvd_unused = fin_q[RSVD_BIT];

  // Transfers run only in UP while the registered enable is still high.
  // The cycle in which the enable drops is the flushing edge, so nothing
  // moves in that cycle either.
  assign active      = (state_q == UP) & fin_q[LINK_EN_BIT];
  assign flush       = ~active;
  assign rx_push     = active & (fin_q[RX_REQ_BIT] != rx_ack_q) & ~rx_full;
  assign rx_pop      = rx_valid & rx_ready;
  assign tx_push     = tx_valid & tx_ready;
  assign tx_ack_seen = (fin_q[TX_ACK_BIT] == tx_req_q);
  assign tx_free     = ~tx_busy_q | tx_ack_seen;
  assign tx_pop      = active & tx_free & ~tx_empty;

  uio_link_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk_i   (UserCLK),
    .rst_i   (RST),
    .flush_i (flush),
    .push_i  (rx_push),
    .data_i  (fin_q[RX_DATA_LSB +: DATA_W]),
    .pop_i   (rx_pop),
    .data_o  (rx_data),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  uio_link_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk_i   (UserCLK),
    .rst_i   (RST),
    .flush_i (flush),
    .push_i  (tx_push),
    .data_i  (tx_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  // Link state machine plus toggle and tx word bookkeeping. SYNC copies the
  // fabric toggles so that a stale request/ack difference left over from a
  // previous session never looks like a new transfer.
  always_comb begin
    state_d   = state_q;
    rx_ack_d  = rx_ack_q;
    tx_req_d  = tx_req_q;
    tx_busy_d = tx_busy_q;
    tx_word_d = tx_word_q;
    case (state_q)
      IDLE: begin
        tx_busy_d = 1'b0;
        if (fin_q[LINK_EN_BIT]) state_d = SYNC;
      end
      SYNC: begin
        rx_ack_d = fin_q[RX_REQ_BIT];
        tx_req_d = fin_q[TX_ACK_BIT];
        state_d  = UP;
      end
      UP: begin
        if (!fin_q[LINK_EN_BIT]) begin
          state_d   = IDLE;
          tx_busy_d = 1'b0;
        end else begin
          if (rx_push) rx_ack_d = ~rx_ack_q;
          if (tx_pop) begin
            tx_word_d = tx_head;
            tx_req_d  = ~tx_req_q;
            tx_busy_d = 1'b1;
          end else if (tx_ack_seen) begin
            tx_busy_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every fabric-facing output comes from a flop, and every decision uses
  // the registered copy of FIN.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      fin_q     <= '0;
      state_q   <= IDLE;
      rx_ack_q  <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_word_q <= '0;
      link_up_q <= 1'b0;
    end else begin
      fin_q     <= UIO_BOT_FIN;
      state_q   <= state_d;
      rx_ack_q  <= rx_ack_d;
      tx_req_q  <= tx_req_d;
      tx_busy_q <= tx_busy_d;
      tx_word_q <= tx_word_d;
      link_up_q <= (state_d == UP);
    end
  end

  assign UIO_BOT_FOUT[RX_DATA_LSB +: DATA_W] = tx_word_q;
  assign UIO_BOT_FOUT[RX_REQ_BIT]            = rx_ack_q;
  assign UIO_BOT_FOUT[TX_ACK_BIT]            = tx_req_q;
  assign UIO_BOT_FOUT[RSVD_BIT]              = rx_full;
  assign UIO_BOT_FOUT[LINK_EN_BIT]           = link_up_q;

  assign rx_valid = ~rx_empty;
  assign tx_ready = link_up_q & ~tx_full;
  assign link_up  = link_up_q;

endmodule
